// File: rtl/cpu65el02_muldiv.sv
// cpu65el02_muldiv: multi-cycle 8/16-bit signed/unsigned shift-add multiply and restoring divide
// returning new A/D values and V/Z/N flags to writeback.
module cpu65el02_muldiv (
    input  logic        Clk,
    input  logic        nReset,
    input  logic        Start,
    input  logic        Op,
    input  logic        Size,
    input  logic        Signed,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [15:0] D,
    output logic [15:0] Y,
    output logic [15:0] YD,
    output logic        Busy,
    output logic        Done,
    output logic        OutFlagV,
    output logic        OutFlagZ,
    output logic        OutFlagN
);
    typedef enum logic [2:0] {IDLE, PREP, RUN, FIX, DONE} state_t;
    state_t state;
    logic op, sz8, sgn, qSign, rSign;
    logic [15:0] a, b, d, m, hi;
    logic [31:0] lo;
    logic [5:0] cnt;
    logic [15:0] wMask, aMag, bMag, divDiff, remS;
    logic [31:0] dMask, dd, ddMag, res, resS, lim;
    logic aSign, bSign, ddSign, bZero, divGe, ovf;
    logic [16:0] mulSum, divShift;
    assign wMask = sz8 ? 16'h00FF : 16'hFFFF;
    assign dMask = sz8 ? 32'h0000FFFF : 32'hFFFFFFFF;
    assign aSign = sgn & (sz8 ? a[7] : a[15]);
    assign bSign = sgn & (sz8 ? b[7] : b[15]);
    assign ddSign = sgn & (sz8 ? d[7] : d[15]);
    assign aMag = aSign ? (-a) & wMask : a;
    assign bMag = bSign ? (-b) & wMask : b;
    assign dd = sz8 ? {16'h0000, d[7:0], a[7:0]} : {d, a};
    assign ddMag = ddSign ? (-dd) & dMask : dd;
    assign bZero = (b == 16'h0000);
    // hi is the MUL accumulator or the DIV partial remainder; lo holds multiplier or dividend/quotient
    assign mulSum = {1'b0, hi} + (lo[0] ? {1'b0, m} : 17'h00000);
    assign divShift = {hi, lo[31]};
    assign divGe = divShift >= {1'b0, m};
    assign divDiff = divShift[15:0] - m;
    assign res = op ? lo : (sz8 ? {16'h0000, hi[7:0], lo[15:8]} : {hi, lo[15:0]});
    assign resS = qSign ? (-res) & dMask : res;
    assign remS = rSign ? (-hi) & wMask : hi;
    assign lim = (sgn ? (sz8 ? 32'h0000007F : 32'h00007FFF) : {16'h0000, wMask}) + {31'h00000000, qSign};
    assign ovf = res > lim;

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
            {op, sz8, sgn, qSign, rSign} <= '0;
            {a, b, d, m, hi} <= '0;
            lo <= '0;
            cnt <= '0;
            Y <= '0;
            YD <= '0;
            Busy <= 1'b0;
            Done <= 1'b0;
            OutFlagV <= 1'b0;
            OutFlagZ <= 1'b0;
            OutFlagN <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= Start ? PREP : IDLE;
                    if (Start) begin
                        Busy <= 1'b1;
                        op <= Op;
                        sz8 <= Size;
                        sgn <= Signed;
                        a <= Size ? {8'h00, A[7:0]} : A;
                        b <= Size ? {8'h00, B[7:0]} : B;
                        d <= Size ? {8'h00, D[7:0]} : D;
                    end
                end
                PREP: begin
                    m <= bMag;
                    hi <= 16'h0000;
                    lo <= op ? (sz8 ? {ddMag[15:0], 16'h0000} : ddMag) : {16'h0000, aMag};
                    qSign <= (op ? ddSign : aSign) ^ bSign;
                    rSign <= ddSign;
                    cnt <= op ? (sz8 ? 6'd16 : 6'd32) : (sz8 ? 6'd8 : 6'd16);
                    state <= (op && bZero) ? FIX : RUN;
                end
                RUN: begin
                    hi <= op ? (divGe ? divDiff : divShift[15:0]) : mulSum[16:1];
                    lo <= op ? {lo[30:0], divGe} : {16'h0000, mulSum[0], lo[15:1]};
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) state <= FIX;
                end
                FIX: begin
                    Y <= (op && bZero) ? wMask : resS[15:0] & wMask;
                    YD <= op ? (bZero ? a : remS) : (sz8 ? {8'h00, resS[15:8]} : resS[31:16]);
                    OutFlagV <= op & (bZero | ovf);
                    OutFlagZ <= ~(op & bZero) & (res == 32'h00000000);
                    OutFlagN <= (op & bZero) | (op ? (sz8 ? resS[7] : resS[15]) : (sz8 ? resS[15] : resS[31]));
                    Busy <= 1'b0;
                    Done <= 1'b1;
                    state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu65el02_muldiv.sv
// tb_cpu65el02_muldiv: directed and random MUL/DIV checks against an integer-arithmetic model,
// covering latency, Busy/Done timing, flags, ignored Start and asynchronous reset.
module tb_cpu65el02_muldiv;
    logic Clk = 1'b0, nReset = 1'b0, Start = 1'b0, Op = 1'b0, Size = 1'b0, Signed = 1'b0;
    logic [15:0] A = '0, B = '0, D = '0;
    logic [15:0] Y, YD;
    logic Busy, Done, OutFlagV, OutFlagZ, OutFlagN;
    int compared = 0, mismatched = 0;

    cpu65el02_muldiv dut (
        .Clk(Clk), .nReset(nReset), .Start(Start), .Op(Op), .Size(Size), .Signed(Signed),
        .A(A), .B(B), .D(D), .Y(Y), .YD(YD), .Busy(Busy), .Done(Done),
        .OutFlagV(OutFlagV), .OutFlagZ(OutFlagZ), .OutFlagN(OutFlagN)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void model(input bit op, sz, sg, input logic [15:0] a, b, d,
                                  output logic [15:0] y, yd, output bit v, z, n, output int lat);
        int w;
        longint wm, dm, ua, ub, ud, av, bv, dd, dv, p, q, r;
        w = sz ? 8 : 16;
        wm = (64'sd1 <<< w) - 1;
        dm = (64'sd1 <<< (2 * w)) - 1;
        ua = longint'(a) & wm;
        ub = longint'(b) & wm;
        ud = longint'(d) & wm;
        av = (sg && ua[w-1]) ? ua - (wm + 1) : ua;
        bv = (sg && ub[w-1]) ? ub - (wm + 1) : ub;
        if (!op) begin
            p = av * bv;
            y = 16'(p & wm);
            yd = 16'((p & dm) >> w);
            n = p[2*w-1];
            z = (p == 0);
            v = 1'b0;
            lat = w + 3;
        end else if (bv == 0) begin
            y = 16'(wm);
            yd = 16'(ua);
            v = 1'b1;
            n = 1'b1;
            z = 1'b0;
            lat = 3;
        end else begin
            dd = (ud << w) | ua;
            dv = (sg && dd[2*w-1]) ? dd - (dm + 1) : dd;
            q = dv / bv;
            r = dv % bv;
            v = sg ? (q < -((wm + 1) / 2) || q > wm / 2) : (q > wm);
            y = 16'(q & wm);
            yd = 16'(r & wm);
            n = q[w-1];
            z = (q == 0);
            lat = 2 * w + 3;
        end
    endfunction

    // Starts an operation in the current cycle; returns in the Done cycle (1 ns after its edge).
    // A nonzero poke re-asserts Start with altered operands in that cycle of the operation.
    task automatic run(input string tag, input bit op, sz, sg, input logic [15:0] a, b, d, input int poke);
        logic [15:0] ey, eyd;
        bit ev, ez, en;
        int lat, cyc, busyCnt;
        model(op, sz, sg, a, b, d, ey, eyd, ev, ez, en, lat);
        Op = op; Size = sz; Signed = sg; A = a; B = b; D = d; Start = 1'b1;
        cyc = 0;
        busyCnt = 0;
        do begin
            @(posedge Clk);
            #1;
            cyc++;
            Start = (poke != 0 && cyc == poke);
            if (Start) begin
                A = ~a; B = b ^ 16'h5A3C; D = ~d; Op = ~op;
            end
            if (!Done && Busy) busyCnt++;
        end while (!Done && cyc < 80);
        Start = 1'b0;
        check({tag, " latency"}, cyc, lat);
        check({tag, " busy cycles"}, busyCnt, lat - 1);
        check({tag, " busy at done"}, {31'h0, Busy}, 32'h0);
        check({tag, " Y"}, {16'h0, Y}, {16'h0, ey});
        check({tag, " YD"}, {16'h0, YD}, {16'h0, eyd});
        check({tag, " V"}, {31'h0, OutFlagV}, {31'h0, ev});
        check({tag, " N"}, {31'h0, OutFlagN}, {31'h0, en});
        if (!(op && ev && ((sz ? {8'h00, b[7:0]} : b) != 16'h0000)))
            check({tag, " Z"}, {31'h0, OutFlagZ}, {31'h0, ez});
    endtask

    task automatic checkZero(input string tag);
        check({tag, " Y"}, {16'h0, Y}, 32'h0);
        check({tag, " YD"}, {16'h0, YD}, 32'h0);
        check({tag, " Busy"}, {31'h0, Busy}, 32'h0);
        check({tag, " Done"}, {31'h0, Done}, 32'h0);
        check({tag, " flags"}, {29'h0, OutFlagV, OutFlagZ, OutFlagN}, 32'h0);
    endtask

    initial begin
        #1;
        checkZero("reset");
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        nReset = 1'b1;
        @(posedge Clk);
        #1;
        run("mul16u", 1'b0, 1'b0, 1'b0, 16'h1234, 16'h0100, 16'h0000, 0);
        @(posedge Clk);
        #1;
        check("done pulse", {31'h0, Done}, 32'h0);
        check("hold Y", {16'h0, Y}, 32'h3400);
        check("hold YD", {16'h0, YD}, 32'h0012);
        run("mul8s", 1'b0, 1'b1, 1'b1, 16'h00FD, 16'h0005, 16'h0000, 0);
        run("div16s", 1'b1, 1'b0, 1'b1, 16'hFFF9, 16'h0002, 16'hFFFF, 0);
        run("div0_16", 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 0);
        run("div0_8", 1'b1, 1'b1, 1'b1, 16'h1234, 16'hAB00, 16'h0077, 0);
        run("div16u ovf", 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0001, 0);
        run("div8s ovf", 1'b1, 1'b1, 1'b1, 16'h1280, 16'h00FF, 16'h00FF, 0);
        run("mul16s min", 1'b0, 1'b0, 1'b1, 16'h8000, 16'h8000, 16'h0000, 0);
        run("div16u poke", 1'b1, 1'b0, 1'b0, 16'h3456, 16'h0123, 16'h0012, 8);
        run("mul8u poke", 1'b0, 1'b1, 1'b0, 16'h00C7, 16'h00E3, 16'h0000, 4);
        for (int i = 0; i < 60; i++) begin
            logic [15:0] ra, rb, rd;
            bit rop, rsz, rsg;
            rop = 1'($urandom);
            rsz = 1'($urandom);
            rsg = 1'($urandom);
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
            rd = 16'($urandom);
            if ($urandom_range(0, 1) == 0) rd = (rsz ? ra[7] : ra[15]) ? 16'hFFFF : 16'h0000;
            run($sformatf("rand%0d", i), rop, rsz, rsg, ra, rb, rd, 0);
        end
        Op = 1'b1; Size = 1'b0; Signed = 1'b0; A = 16'h5555; B = 16'h0033; D = 16'h0011; Start = 1'b1;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (5) @(posedge Clk);
        #2;
        check("pre-reset busy", {31'h0, Busy}, 32'h1);
        nReset = 1'b0;
        #1;
        checkZero("midrun reset");
        @(negedge Clk);
        nReset = 1'b1;
        @(posedge Clk);
        #1;
        checkZero("after release");
        run("mul after reset", 1'b0, 1'b0, 1'b0, 16'h0003, 16'h0004, 16'h0000, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
